// File: rtl/call_stack_pkg.sv
// Shared core defines (PC width, execute-state codes, stack depth) and the
// call-stack operation decode used by call_stack.
`ifndef PC_WIDTH
`define PC_WIDTH 9
`endif
`ifndef EX_STATE_BITS
`define EX_STATE_BITS 4
`endif
`ifndef STACK_DEPTH
`define STACK_DEPTH 2
`endif
`ifndef FE_Q1
`define FE_Q1       4'h0
`define FE_Q2       4'h1
`define FE_Q3       4'h2
`define FE_Q4       4'h3
`define EX_Q1       4'h4
`define EX_Q2       4'h5
`define EX_Q3       4'h6
`define EX_Q4_NOP   4'h7
`define EX_Q4_CALL  4'h8
`define EX_Q4_RETLW 4'h9
`define EX_Q4_GOTO  4'hA
`define EX_Q4_ALU   4'hB
`endif

package call_stack_pkg;

  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_PUSH = 2'd1,
    OP_POP  = 2'd2
  } stack_op_e;

  // Only the two Q4 call/return codes touch the stack; every other code idles.
  function automatic stack_op_e decode_op(input logic [`EX_STATE_BITS-1:0] state);
    stack_op_e op;
    op = OP_NONE;
    if (state == `EX_Q4_CALL)       op = OP_PUSH;
    else if (state == `EX_Q4_RETLW) op = OP_POP;
    return op;
  endfunction

endpackage

// File: rtl/call_stack.sv
// PIC16C5x return-address stack: shift-register semantics, top entry on stackOut.
// Define CALL_STACK_FLAGS_EN to add sticky overflow/underflow flags and flagClr.
module call_stack
  import call_stack_pkg::*;
#(
  parameter int STACK_DEPTH = `STACK_DEPTH,
  parameter int PC_W        = `PC_WIDTH
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [`EX_STATE_BITS-1:0]        executeState,
  input  logic [PC_W-1:0]                  pcIn,
  output logic [PC_W-1:0]                  stackOut,
  output logic [$clog2(STACK_DEPTH+1)-1:0] depth
`ifdef CALL_STACK_FLAGS_EN
  ,
  output logic                             overflow,
  output logic                             underflow,
  input  logic                             flagClr
`endif
);

  localparam int DW = $clog2(STACK_DEPTH + 1);
  localparam logic [DW-1:0] DEPTH_MAX = DW'(STACK_DEPTH);

  logic [PC_W-1:0] entry_q [STACK_DEPTH];
  logic [PC_W-1:0] entry_d [STACK_DEPTH];
  logic [DW-1:0]   depth_q, depth_d;
  stack_op_e       op;

  assign op = decode_op(executeState);

  always_comb begin
    entry_d = entry_q;
    depth_d = depth_q;
    case (op)
      OP_PUSH: begin
        // The deepest entry falls off the end; the counter saturates.
        for (int i = STACK_DEPTH - 1; i > 0; i--) entry_d[i] = entry_q[i-1];
        entry_d[0] = pcIn;
        if (depth_q != DEPTH_MAX) depth_d = depth_q + 1'b1;
      end
      OP_POP: begin
        // Bottom entry keeps its value, so repeated pops keep returning it.
        for (int i = 0; i < STACK_DEPTH - 1; i++) entry_d[i] = entry_q[i+1];
        if (depth_q != '0) depth_d = depth_q - 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entry_q <= '{default: '0};
      depth_q <= '0;
    end else begin
      entry_q <= entry_d;
      depth_q <= depth_d;
    end
  end

  assign stackOut = entry_q[0];
  assign depth    = depth_q;

`ifdef CALL_STACK_FLAGS_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  // A set event at the same edge as flagClr takes priority over the clear.
  always_comb begin
    overflow_d  = flagClr ? 1'b0 : overflow_q;
    underflow_d = flagClr ? 1'b0 : underflow_q;
    if (op == OP_PUSH && depth_q == DEPTH_MAX) overflow_d  = 1'b1;
    if (op == OP_POP  && depth_q == '0)        underflow_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

endmodule

// File: doc/call_stack.md
Name: call_stack

Overview:
- Hardware return-address stack for the PIC16C5x core; the other end of the program counter's stack interface.
- Captures the current PC on CALL and presents the top-of-stack return address, which the PC loads on RETLW.
- Reproduces PIC16C5x shift-register semantics: the deepest entry is lost on overflow, and the bottom entry is retained on pop.
- Driven directly by the execute-state decode. No handshake; one push or pop per instruction cycle.

Parameters:
- STACK_DEPTH, 2, number of return-address entries (≥1); PIC16C5x uses 2.
- PC_W, `PC_WIDTH (9), width of each entry and of pcIn/stackOut.

Ports:
- clk  input  1  core clock; all state updates on rising edge
- rst  input  1  reset, asynchronous, active-high; clears all state immediately
- executeState  input  `EX_STATE_BITS  execute-stage state code from the control unit
- pcIn  input  PC_W  current PC register value (already points at the return address)
- stackOut  output  PC_W  top-of-stack entry, driven directly from register entry[0]
- depth  output  $clog2(STACK_DEPTH+1)  number of valid entries
- overflow  output  1  sticky flag; present only with CALL_STACK_FLAGS_EN
- underflow  output  1  sticky flag; present only with CALL_STACK_FLAGS_EN
- flagClr  input  1  synchronous clear of both flags; present only with CALL_STACK_FLAGS_EN

Behaviour:
- Storage: entry[0..STACK_DEPTH-1], entry[0] = top. stackOut = entry[0] combinationally, no extra register stage.
- Reset (rst=1, async): all entries = 0, depth = 0, flags = 0; stackOut = 0 immediately. This holds even mid-instruction.
- Push (executeState == `EX_Q4_CALL at a rising edge):
  - entry[i+1] <= entry[i] for i = 0..STACK_DEPTH-2; entry[0] <= pcIn. Old entry[STACK_DEPTH-1] is discarded.
  - pcIn is stored unmodified; this block does no increment.
  - depth <= min(depth+1, STACK_DEPTH).
  - If depth == STACK_DEPTH before the push, overflow is set (flag build).
- Pop (executeState == `EX_Q4_RETLW at a rising edge):
  - The PC samples stackOut at this same edge, so the pre-pop entry[0] is the value returned. Zero added latency.
  - entry[i] <= entry[i+1] for i = 0..STACK_DEPTH-2; entry[STACK_DEPTH-1] holds its value (bottom duplicated).
  - depth <= depth-1, floored at 0.
  - If depth == 0 before the pop, entries still shift as above and underflow is set (flag build).
- All other executeState codes: no state change, including FE/EX Q1–Q3 and every other EX_Q4_* code.
  - Instructions flushed by skip/goto reach this block as EX_Q4_NOP, so they never push or pop.
- Push and pop are mutually exclusive by construction: executeState is a single encoded value.
- STACK_DEPTH = 1: a push overwrites entry[0]; a pop leaves entry[0] unchanged.
- New values on stackOut/depth are visible from the cycle after the updating edge.

Optional Feature:
- Macro: CALL_STACK_FLAGS_EN.
- Defined: overflow/underflow ports and registers exist.
  - Set as described in Behaviour; stay set until flagClr=1 at an edge or rst.
  - If a set event and flagClr coincide at the same edge, the set wins.
- Undefined: flag ports, registers and flagClr are absent. Stack behaviour is otherwise identical.

Decomposition:
- Shared header define.v supplies `PC_WIDTH, `EX_STATE_BITS, `EX_Q4_CALL and `EX_Q4_RETLW.
- Add `STACK_DEPTH (default 2) to define.v so the top level and the PC agree on depth.
- No sub-module: the shift array and counter are small and belong in one module.

Test Plan:
- Reset: assert rst asynchronously mid-cycle -> stackOut = 0x000 and depth = 0 immediately, without waiting for a clock edge.
- Nesting, STACK_DEPTH=2:
  - Push pcIn = 0x005, then push 0x010 -> stackOut = 0x010, depth = 2.
  - Pop -> PC-side sample = 0x010; afterwards stackOut = 0x005, depth = 1.
  - Pop again -> sample = 0x005; stackOut stays 0x005, depth = 0.
- Overflow: push 0x001, 0x002, 0x003 -> entries {0x003, 0x002}, depth = 2; with the flag build, overflow = 1 after the third push. Two pops return 0x003, then 0x002.
- Underflow: pop at depth 0 with entry[0] = 0x07F -> stackOut stays 0x07F, depth = 0, underflow = 1. A flagClr pulse then clears both flags.
- Idle: hold depth = 1 while cycling executeState through `EX_Q1, `EX_Q4_GOTO, `EX_Q4_NOP with pcIn toggling -> stackOut and depth unchanged.
- Reset mid-operation: depth = 2, assert rst between edges for half a cycle -> all zero at once. A push of 0x0AA after release -> stackOut = 0x0AA, depth = 1.
